mulu_seq_x8y8: RTL

MULU_SEQ_X8Y8 -- requirements
Module: mulu_seq_x8y8

---
 rtl/mulu_seq_x8y8_pkg.sv | 20 ++
 rtl/mulu_seq_x8y8_x2y2.sv | 17 +
 rtl/mulu_seq_x8y8.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mulu_seq_x8y8_pkg.sv
// Shared constants and state encoding for the sequential 8x8 radix-4 multiplier.
// Optional feature macro used by the design: MULU_SEQ_ZERO_SKIP_EN.
package mulu_seq_x8y8_pkg;

    localparam int unsigned DIG_W  = 2;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DPROD_W = 2 * DIG_W;

    // Last digit-pair index; the edge that processes it completes the product.
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mulu_seq_x8y8_x2y2.sv
// Combinational 2x2 unsigned digit multiplier.
// Ports:
//   a, b    : 2-bit unsigned digits
//   prod_c  : 4-bit unsigned product (combinational)
module mulu_x2y2
    import mulu_seq_x8y8_pkg::*;
(
    input  logic [DIG_W-1:0]   a,
    input  logic [DIG_W-1:0]   b,
    output logic [DPROD_W-1:0] prod_c
);

    always_comb begin
        prod_c = DPROD_W'(a) * DPROD_W'(b);
    end

endmodule

// File: rtl/mulu_seq_x8y8.sv
// Sequential 8x8 unsigned multiplier: accumulates sixteen 2x2 digit products,
// one per cycle, into a 16-bit accumulator.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : operation request, accepted when in_ready=1
//   x, y       : 8-bit unsigned operands, sampled on the accepting edge
//   in_ready   : high in IDLE and DONE
//   busy       : high in RUN
//   p          : 16-bit product (accumulator), valid while p_valid=1
//   p_valid    : high in DONE
// Build option: define MULU_SEQ_ZERO_SKIP_EN to finish zero-operand requests
// in a single edge without entering RUN.
module mulu_seq_x8y8
    import mulu_seq_x8y8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic              in_ready,
    output logic              busy,
    output logic [PROD_W-1:0] p,
    output logic              p_valid
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     x_q, x_d;
    logic [OP_W-1:0]     y_q, y_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                p_valid_q, p_valid_d;

    logic [DIG_W-1:0]    x_dig_c;
    logic [DIG_W-1:0]    y_dig_c;
    logic [DPROD_W-1:0]  dprod_c;
    logic [CNT_W-1:0]    shamt_c;
    logic [PROD_W-1:0]   pp_c;

    // Digit selection: cnt[1:0] walks x digits, cnt[3:2] walks y digits.
    always_comb begin
        x_dig_c = x_q[{cnt_q[1:0], 1'b0} +: DIG_W];
        y_dig_c = y_q[{cnt_q[3:2], 1'b0} +: DIG_W];
        shamt_c = CNT_W'({cnt_q[1:0], 1'b0}) + CNT_W'({cnt_q[3:2], 1'b0});
        pp_c    = PROD_W'(dprod_c) << shamt_c;
    end

    mulu_x2y2 u_x2y2 (
        .a      (x_dig_c),
        .b      (y_dig_c),
        .prod_c (dprod_c)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef MULU_SEQ_ZERO_SKIP_EN
                    if ((x == '0) || (y == '0)) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                acc_d = acc_q + pp_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d     = (state_d == ST_RUN);
        p_valid_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            p_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            p_valid_q  <= p_valid_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign p_valid  = p_valid_q;
    assign p        = acc_q;

endmodule
